// File: rtl/tensor_to_rgb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tensor_to_rgb_pkg
// Description : Shared definitions for the bf16-planes-to-RGB565 DMA engine:
//               CSR word indices, bf16 field constants and the FSM state type.
//               Optional build macro used by this block: TENSOR_TO_RGB_ROUND_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package tensor_to_rgb_pkg;

   // CSR word indices on the slave port
   localparam logic [3:0] CSR_CTRL  = 4'd0;
   localparam logic [3:0] CSR_DST   = 4'd1;
   localparam logic [3:0] CSR_RED   = 4'd2;
   localparam logic [3:0] CSR_GREEN = 4'd3;
   localparam logic [3:0] CSR_BLUE  = 4'd4;
   localparam logic [3:0] CSR_COUNT = 4'd5;

   // bf16 exponent landmarks
   localparam logic [7:0] BF16_EXP_BIAS = 8'd127;
   localparam logic [7:0] BF16_EXP_SAT  = 8'd133;
   localparam logic [7:0] BF16_EXP_MAX  = 8'hFF;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RD_R   = 3'd1,
      RD_G   = 3'd2,
      RD_B   = 3'd3,
      WR_PIX = 3'd4
   } state_t;

endpackage
`default_nettype wire

// File: rtl/tensor_to_rgb_bf16_to_uint6.sv
`default_nettype none
// ============================================================================
// Module      : bf16_to_uint6
// Description : Combinational bf16 -> unsigned 6-bit converter with
//               saturation. Negatives, zero, denormals and NaN map to 0;
//               +Inf and values >= 64 map to 63. Truncates toward zero by
//               default; rounds half-up when TENSOR_TO_RGB_ROUND_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module bf16_to_uint6
   import tensor_to_rgb_pkg::*;
(
   input  logic [15:0] bf16,
   output logic [5:0]  uint6
);

   logic       w_sign;
   logic [7:0] w_exp;
   logic [6:0] w_man;
   logic [8:0] w_mant_full;
   logic [7:0] w_rshift;
   logic [8:0] w_scaled;

   assign w_sign      = bf16[15];
   assign w_exp       = bf16[14:7];
   assign w_man       = bf16[6:0];
   assign w_mant_full = {2'b01, w_man};
   // 1.m is held as an 8-bit integer scaled by 2^7; shift right by 7-(e-127)
   assign w_rshift    = (BF16_EXP_SAT + 8'd1) - w_exp;

`ifdef TENSOR_TO_RGB_ROUND_EN
   logic [8:0] w_half;
   // Half of one output LSB at the current scale, added before truncation
   assign w_half   = 9'd64 >> (w_exp - BF16_EXP_BIAS);
   assign w_scaled = (w_mant_full + w_half) >> w_rshift;
`else
   assign w_scaled = w_mant_full >> w_rshift;
`endif

   // Classify the operand and select the saturated / scaled result
   always_comb begin
      uint6 = 6'd0;
      if (w_sign || (w_exp == 8'd0)) begin
         uint6 = 6'd0;
      end else if (w_exp == BF16_EXP_MAX) begin
         uint6 = (w_man == 7'd0) ? 6'd63 : 6'd0;
      end else if (w_exp >= BF16_EXP_SAT) begin
         uint6 = 6'd63;
      end else if (w_exp < BF16_EXP_BIAS) begin
`ifdef TENSOR_TO_RGB_ROUND_EN
         // [0.5, 1.0) rounds up to 1
         if (w_exp == (BF16_EXP_BIAS - 8'd1)) begin
            uint6 = 6'd1;
         end
`endif
      end else if (w_scaled > 9'd63) begin
         // only reachable when rounding carries 63.5+ up to 64
         uint6 = 6'd63;
      end else begin
         uint6 = w_scaled[5:0];
      end
   end

endmodule
`default_nettype wire

// File: rtl/tensor_to_rgb.sv
`default_nettype none
// ============================================================================
// Module      : tensor_to_rgb
// Description : DMA engine reading red/green/blue bf16 planes over a 16-bit
//               Avalon-MM master, converting each element to 6 bits and
//               writing packed RGB565 pixels to a destination buffer.
//               CSRs on an Avalon-MM slave. Build macro
//               TENSOR_TO_RGB_ROUND_EN selects round-half-up conversion.
// Revision    : 1.0 - initial release
// ============================================================================
module tensor_to_rgb
   import tensor_to_rgb_pkg::*;
(
   input  logic        clock,
   input  logic        clock_sreset,
   input  logic [3:0]  s_address,
   output logic [31:0] s_readdata,
   input  logic [31:0] s_writedata,
   input  logic        s_read,
   input  logic        s_write,
   output logic        s_waitrequest,
   output logic [31:0] m_address,
   output logic [15:0] m_writedata,
   input  logic [15:0] m_readdata,
   output logic [1:0]  m_byteenable,
   output logic        m_read,
   output logic        m_write,
   input  logic        m_waitrequest
);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_dst_ptr;
   logic [31:0] r_red_ptr;
   logic [31:0] r_green_ptr;
   logic [31:0] r_blue_ptr;
   logic [23:0] r_count;
   logic [23:0] r_offset;
   logic [15:0] r_red_bf16;
   logic [15:0] r_green_bf16;
   logic [15:0] r_blue_bf16;
   logic        r_busy;
   logic        r_go;
   logic        r_read_lat;
   logic [5:0]  w_red6;
   logic [5:0]  w_green6;
   logic [5:0]  w_blue6;
   logic [31:0] w_offset_bytes;
   logic        w_last;
   logic        w_unused_lsbs;

   assign w_offset_bytes = {7'd0, r_offset, 1'b0};
   assign w_last         = (r_offset == (r_count - 24'd1));
   assign m_byteenable   = 2'b11;
   // Red and blue keep only the upper five bits of the converted value
   assign m_writedata    = {w_red6[5:1], w_green6, w_blue6[5:1]};
   assign w_unused_lsbs  = w_red6[0] ^ w_blue6[0];
   // Reads stall exactly one cycle; r_read_lat toggles back so
   // back-to-back reads each get their own stall
   assign s_waitrequest  = s_read & ~r_read_lat;

   bf16_to_uint6 u_cvt_red   (.bf16(r_red_bf16),   .uint6(w_red6));
   bf16_to_uint6 u_cvt_green (.bf16(r_green_bf16), .uint6(w_green6));
   bf16_to_uint6 u_cvt_blue  (.bf16(r_blue_bf16),  .uint6(w_blue6));

   // Go pulse and read-latency flag
   always_ff @(posedge clock) begin
      if (clock_sreset) begin
         r_go       <= 1'b0;
         r_read_lat <= 1'b0;
      end else begin
         r_go       <= s_write && (s_address == CSR_CTRL) && s_writedata[0];
         r_read_lat <= s_read && !r_read_lat;
      end
   end

   // Software-written job descriptor (no reset: undefined until written)
   always_ff @(posedge clock) begin
      if (s_write) begin
         case (s_address)
            CSR_DST:   r_dst_ptr   <= s_writedata;
            CSR_RED:   r_red_ptr   <= s_writedata;
            CSR_GREEN: r_green_ptr <= s_writedata;
            CSR_BLUE:  r_blue_ptr  <= s_writedata;
            CSR_COUNT: r_count     <= s_writedata[23:0];
            default:   ;
         endcase
      end
   end

   // Registered CSR read mux, valid on the cycle after the stall
   always_ff @(posedge clock) begin
      case (s_address)
         CSR_CTRL:  s_readdata <= {31'd0, r_busy};
         CSR_DST:   s_readdata <= r_dst_ptr;
         CSR_RED:   s_readdata <= r_red_ptr;
         CSR_GREEN: s_readdata <= r_green_ptr;
         CSR_BLUE:  s_readdata <= r_blue_ptr;
         CSR_COUNT: s_readdata <= {8'd0, r_count};
         default:   s_readdata <= 32'd0;
      endcase
   end

   // FSM state register
   always_ff @(posedge clock) begin
      if (clock_sreset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and master-port outputs
   always_comb begin
      w_state_nxt = r_state;
      m_read      = 1'b0;
      m_write     = 1'b0;
      m_address   = 32'd0;
      case (r_state)
         IDLE: begin
            if (r_go && (r_count != 24'd0)) begin
               w_state_nxt = RD_R;
            end
         end
         RD_R: begin
            m_read    = 1'b1;
            m_address = r_red_ptr + w_offset_bytes;
            if (!m_waitrequest) w_state_nxt = RD_G;
         end
         RD_G: begin
            m_read    = 1'b1;
            m_address = r_green_ptr + w_offset_bytes;
            if (!m_waitrequest) w_state_nxt = RD_B;
         end
         RD_B: begin
            m_read    = 1'b1;
            m_address = r_blue_ptr + w_offset_bytes;
            if (!m_waitrequest) w_state_nxt = WR_PIX;
         end
         WR_PIX: begin
            m_write   = 1'b1;
            m_address = r_dst_ptr + w_offset_bytes;
            if (!m_waitrequest) w_state_nxt = w_last ? IDLE : RD_R;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Busy flag and pixel offset
   always_ff @(posedge clock) begin
      if (clock_sreset) begin
         r_busy   <= 1'b0;
         r_offset <= 24'd0;
      end else begin
         case (r_state)
            IDLE: begin
               r_offset <= 24'd0;
               if (r_go && (r_count != 24'd0)) r_busy <= 1'b1;
            end
            WR_PIX: begin
               if (!m_waitrequest) begin
                  if (w_last) r_busy   <= 1'b0;
                  else        r_offset <= r_offset + 24'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // Capture each plane element in its accept cycle
   always_ff @(posedge clock) begin
      if (!m_waitrequest) begin
         if (r_state == RD_R) r_red_bf16   <= m_readdata;
         if (r_state == RD_G) r_green_bf16 <= m_readdata;
         if (r_state == RD_B) r_blue_bf16  <= m_readdata;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_tensor_to_rgb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_tensor_to_rgb
// Description : Self-checking bench for tensor_to_rgb. Single-pixel vector
//               table, a stalled multi-pixel job, and control corner cases.
//               Expected pixels come from a real-arithmetic reference model
//               or hand-derived constants; writes are checked via a queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tensor_to_rgb;

   logic        clock = 1'b0;
   logic        clock_sreset;
   logic [3:0]  s_address;
   logic [31:0] s_readdata;
   logic [31:0] s_writedata;
   logic        s_read;
   logic        s_write;
   logic        s_waitrequest;
   logic [31:0] m_address;
   logic [15:0] m_writedata;
   logic [15:0] m_readdata;
   logic [1:0]  m_byteenable;
   logic        m_read;
   logic        m_write;
   logic        m_waitrequest;

   tensor_to_rgb dut (
      .clock         (clock),
      .clock_sreset  (clock_sreset),
      .s_address     (s_address),
      .s_readdata    (s_readdata),
      .s_writedata   (s_writedata),
      .s_read        (s_read),
      .s_write       (s_write),
      .s_waitrequest (s_waitrequest),
      .m_address     (m_address),
      .m_writedata   (m_writedata),
      .m_readdata    (m_readdata),
      .m_byteenable  (m_byteenable),
      .m_read        (m_read),
      .m_write       (m_write),
      .m_waitrequest (m_waitrequest)
   );

   always #5 clock = ~clock;

   // Word-addressed memory, fixed-latency read data
   logic [15:0] mem [0:32767];
   assign m_readdata = mem[m_address[15:1]];

   int checks = 0;
   int passed = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Reference conversion in real arithmetic
   function automatic logic [5:0] ref_u6(input logic [15:0] x);
      real v;
      real q;
      int  e;
      e = int'(x[14:7]);
      if (x[15] || e == 0) return 6'd0;
      if (e == 255) return (x[6:0] == 7'd0) ? 6'd63 : 6'd0;
      v = 1.0 + real'(x[6:0]) / 128.0;
      for (int i = 127; i < e; i++) v = v * 2.0;
      for (int i = e; i < 127; i++) v = v / 2.0;
`ifdef TENSOR_TO_RGB_ROUND_EN
      q = $floor(v + 0.5);
`else
      q = $floor(v);
`endif
      if (q > 63.0) q = 63.0;
      return 6'($rtoi(q));
   endfunction

   function automatic logic [15:0] ref_pix(input logic [15:0] r, input logic [15:0] g, input logic [15:0] b);
      logic [5:0] r6, g6, b6;
      r6 = ref_u6(r);
      g6 = ref_u6(g);
      b6 = ref_u6(b);
      return {r6[5:1], g6, b6[5:1]};
   endfunction

   // Scoreboard of expected master writes
   typedef struct {
      logic [31:0] addr;
      logic [15:0] data;
   } wr_t;
   wr_t exp_q[$];

   // Slave-side responder / monitor on the master port
   int          n_reads = 0;
   int          n_writes = 0;
   bit          stall_en = 0;
   int          budget = 0;
   bit          in_req = 0;
   bit          was_stall = 0;
   logic [31:0] hold_addr;
   logic [17:0] hold_ctl;

   always @(negedge clock) begin
      if (was_stall) begin
         check("stall_addr_stable", m_address, hold_addr);
         check("stall_ctl_stable", {14'd0, m_read, m_write, m_writedata}, {14'd0, hold_ctl});
      end
      if (clock_sreset) begin
         m_waitrequest = 1'b0;
         in_req        = 0;
         was_stall     = 0;
      end else if (m_read || m_write) begin
         if (!in_req) begin
            in_req = 1;
            budget = stall_en ? int'($urandom_range(0, 3)) : 0;
         end
         if (budget > 0) begin
            budget--;
            m_waitrequest = 1'b1;
            was_stall     = 1;
            hold_addr     = m_address;
            hold_ctl      = {m_read, m_write, m_writedata};
         end else begin
            m_waitrequest = 1'b0;
            was_stall     = 0;
            in_req        = 0;
            if (m_read) n_reads++;
            if (m_write) begin
               wr_t w;
               n_writes++;
               check("byteenable", {30'd0, m_byteenable}, 32'd3);
               if (exp_q.size() == 0) begin
                  checks++;
                  $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none", m_address, m_writedata);
               end else begin
                  w = exp_q.pop_front();
                  check("wr_addr", m_address, w.addr);
                  check("wr_data", {16'd0, m_writedata}, {16'd0, w.data});
               end
            end
         end
      end else begin
         m_waitrequest = 1'b0;
         was_stall     = 0;
         in_req        = 0;
      end
   end

   task automatic csr_write(input logic [3:0] a, input logic [31:0] d);
      @(negedge clock);
      s_address   = a;
      s_writedata = d;
      s_write     = 1'b1;
      @(posedge clock);
      #1;
      s_write = 1'b0;
   endtask

   task automatic csr_read(input logic [3:0] a, output logic [31:0] d, output int stalls);
      @(negedge clock);
      s_address = a;
      s_read    = 1'b1;
      stalls    = 0;
      #1;
      while (s_waitrequest && stalls < 4) begin
         stalls++;
         @(posedge clock);
         #1;
      end
      d = s_readdata;
      @(posedge clock);
      #1;
      s_read = 1'b0;
   endtask

   task automatic start_job(input logic [23:0] cnt);
      csr_write(4'd1, 32'h0000_4000);
      csr_write(4'd2, 32'h0000_1000);
      csr_write(4'd3, 32'h0000_2000);
      csr_write(4'd4, 32'h0000_3000);
      csr_write(4'd5, {8'd0, cnt});
      csr_write(4'd0, 32'd1);
      repeat (2) @(posedge clock);
   endtask

   task automatic wait_done(input string name);
      logic [31:0] d;
      int          st;
      bit          ok;
      ok = 0;
      for (int i = 0; i < 300; i++) begin
         csr_read(4'd0, d, st);
         if (!d[0]) begin
            ok = 1;
            break;
         end
      end
      check({name, "_done"}, {31'd0, ok}, 32'd1);
      check({name, "_all_writes"}, exp_q.size(), 32'd0);
   endtask

   task automatic load_pixel(input int idx, input logic [15:0] r, input logic [15:0] g,
                             input logic [15:0] b, input logic [15:0] pix);
      wr_t w;
      mem[(32'h1000 >> 1) + idx] = r;
      mem[(32'h2000 >> 1) + idx] = g;
      mem[(32'h3000 >> 1) + idx] = b;
      w.addr = 32'h4000 + 32'(idx * 2);
      w.data = pix;
      exp_q.push_back(w);
   endtask

   typedef struct {
      logic [15:0] r;
      logic [15:0] g;
      logic [15:0] b;
      logic [15:0] pix;
   } vec_t;

   vec_t        vecs [10];
   logic [31:0] d;
   int          st;
   int          r0, w0;
   bit          found;

   initial begin
      clock_sreset  = 1'b1;
      s_address     = 4'd0;
      s_writedata   = 32'd0;
      s_read        = 1'b0;
      s_write       = 1'b0;
      m_waitrequest = 1'b0;

`ifdef TENSOR_TO_RGB_ROUND_EN
      vecs[6] = '{16'h0000, 16'h4020, 16'h0000, 16'h0060};
      vecs[7] = '{16'h8000, 16'h3F00, 16'h0000, 16'h0020};
      vecs[8] = '{16'h4270, 16'h427E, 16'h3FC0, 16'hF7E1};
`else
      vecs[6] = '{16'h0000, 16'h4020, 16'h0000, 16'h0040};
      vecs[7] = '{16'h8000, 16'h3F00, 16'h0000, 16'h0000};
      vecs[8] = '{16'h4270, 16'h427E, 16'h3FC0, 16'hF7E0};
`endif
      vecs[0] = '{16'h4278, 16'h427C, 16'h4278, 16'hFFFF};
      vecs[1] = '{16'h4180, 16'h3F80, 16'hC0A0, 16'h4020};
      vecs[2] = '{16'h0000, 16'h42C8, 16'h0000, 16'h07E0};
      vecs[3] = '{16'h4278, 16'h7FC1, 16'h4278, 16'hF81F};
      vecs[4] = '{16'h0000, 16'h7F80, 16'h0000, 16'h07E0};
      vecs[5] = '{16'h4100, 16'h0001, 16'h4100, 16'h2004};
      vecs[9] = '{16'h3E80, 16'h4140, 16'h0000, 16'h0180};

      repeat (3) @(posedge clock);
      #1;
      clock_sreset = 1'b0;

      // Reset state
      check("reset_m_read", {31'd0, m_read}, 32'd0);
      check("reset_m_write", {31'd0, m_write}, 32'd0);
      csr_read(4'd0, d, st);
      check("reset_busy", d, 32'd0);

      // Single-pixel vector table
      for (int i = 0; i < 10; i++) begin
         r0 = n_reads;
         w0 = n_writes;
         load_pixel(0, vecs[i].r, vecs[i].g, vecs[i].b, vecs[i].pix);
         start_job(24'd1);
         wait_done($sformatf("vec%0d", i));
         check($sformatf("vec%0d_reads", i), n_reads - r0, 32'd3);
         check($sformatf("vec%0d_writes", i), n_writes - w0, 32'd1);
      end

      // Multi-pixel job with random master stalls
      stall_en = 1;
      r0 = n_reads;
      w0 = n_writes;
      for (int i = 0; i < 4; i++) begin
         logic [15:0] rv, gv, bv;
         rv = {($urandom_range(0, 4) == 0), 8'($urandom_range(120, 136)), 7'($urandom_range(0, 127))};
         gv = {($urandom_range(0, 4) == 0), 8'($urandom_range(120, 136)), 7'($urandom_range(0, 127))};
         bv = {($urandom_range(0, 4) == 0), 8'($urandom_range(120, 136)), 7'($urandom_range(0, 127))};
         load_pixel(i, rv, gv, bv, ref_pix(rv, gv, bv));
      end
      start_job(24'd4);
      wait_done("multi");
      check("multi_reads", n_reads - r0, 32'd12);
      check("multi_writes", n_writes - w0, 32'd4);
      stall_en = 0;

      // count == 0: go must not start a transfer
      r0 = n_reads;
      w0 = n_writes;
      csr_write(4'd5, 32'd0);
      csr_write(4'd0, 32'd1);
      repeat (20) @(posedge clock);
      check("cnt0_activity", (n_reads - r0) + (n_writes - w0), 32'd0);
      csr_read(4'd0, d, st);
      check("cnt0_busy", d, 32'd0);

      // go while busy is ignored
      r0 = n_reads;
      w0 = n_writes;
      for (int i = 0; i < 3; i++) begin
         load_pixel(i, vecs[i].r, vecs[i].g, vecs[i].b, vecs[i].pix);
      end
      start_job(24'd3);
      csr_read(4'd0, d, st);
      check("gobusy_busy", d, 32'd1);
      csr_write(4'd0, 32'd1);
      wait_done("gobusy");
      repeat (10) @(posedge clock);
      check("gobusy_reads", n_reads - r0, 32'd9);
      check("gobusy_writes", n_writes - w0, 32'd3);

      // Reset in the middle of the green read
      load_pixel(0, vecs[0].r, vecs[0].g, vecs[0].b, vecs[0].pix);
      start_job(24'd1);
      found = 0;
      for (int i = 0; i < 50 && !found; i++) begin
         @(negedge clock);
         if (m_read && m_address == 32'h0000_2000) found = 1;
      end
      check("rst_reached_rd_g", {31'd0, found}, 32'd1);
      clock_sreset = 1'b1;
      @(posedge clock);
      #1;
      check("rst_m_read", {31'd0, m_read}, 32'd0);
      check("rst_m_write", {31'd0, m_write}, 32'd0);
      clock_sreset = 1'b0;
      exp_q.delete();
      csr_read(4'd0, d, st);
      check("rst_busy", d, 32'd0);
      w0 = n_writes;
      repeat (10) @(posedge clock);
      check("rst_no_writes", n_writes - w0, 32'd0);

      // CSR read timing on index 3
      csr_write(4'd3, 32'hCAFE_1234);
      csr_read(4'd3, d, st);
      check("csr3_stalls", st, 32'd1);
      check("csr3_data", d, 32'hCAFE_1234);
      csr_write(4'd5, 32'hFF12_3456);
      csr_read(4'd5, d, st);
      check("csr5_zero_ext", d, 32'h0012_3456);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   // Global watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("%0d/%0d checks passed", passed, checks + 1);
      $fatal(1);
   end

endmodule
`default_nettype wire
